clk_enable_gen: RTL
===================

# clk_enable_gen

Parametrised multi-channel clock-enable generator: the successor to the fixed 100→25 MHz pixel-tick counter. Each channel emits a one-cycle registered `tick` every `div` enabled clock cycles, with a runtime-programmable divisor that changes glitch-free at the channel's wrap point. Channels can optionally be cascaded, so that a single instance produces aligned pixel, line and frame enables for the VGA timing path.

## Interface
Parameters:
- `NUM_CH`, 2: number of divider channels (≥1).
- `CNT_W`, 8: counter and divisor width; legal divisor range 0..2^CNT_W−1.
- `DEFAULT_DIV`, 4: divisor loaded into every channel on reset (4 gives 25 MHz from a 100 MHz clock).
- `CASCADE`, 0: 0 = every channel counts clock cycles; 1 = channel i>0 counts wraps of channel i−1.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: global count enable.
- `sync_clr` in 1: synchronous realign of all channels.
- `div_wr` in 1: divisor write strobe.
- `div_ch` in $clog2(NUM_CH) (min 1): target channel of the write.
- `div_in` in CNT_W: new divisor value.
- `tick` out NUM_CH: per-channel one-cycle enable pulse.
- `div_pend` out NUM_CH: per-channel flag; 1 while a written divisor is waiting for the wrap.

## Operation
- Per-channel state: `count`, active `div`, `pend_div`, and the `div_pend` flag.
- Advance condition `adv[i]`:
  - Channel 0: `enable`.
  - Channel i>0: `enable` when CASCADE=0; `wrap[i−1]` when CASCADE=1.
- Wrap: `wrap[i]` = `adv[i]` && `div`≥1 && `count`==`div`−1.
- On an `adv[i]` edge:
  - If `wrap[i]`: `count`←0 and `tick[i]`←1. If an update is pending, `div`←`pend_div` and `div_pend`←0.
  - Otherwise: `count`←`count`+1 and `tick[i]`←0.
- No advance: `count` holds and `tick[i]`←0. `tick` is therefore never held high across a disabled cycle.
- `div`=1: tick on every advanced cycle.
- `div`=0: channel is parked. `count` holds at 0, `tick` stays 0, and a pending divisor is applied on the next clock regardless of `adv`.
- Write: `div_wr` && `div_ch`<NUM_CH → `pend_div[div_ch]`←`div_in`, `div_pend`←1. Writes with `div_ch`≥NUM_CH are ignored.
- Write while already pending: last write wins.
- Write in the same cycle as that channel's wrap: bypass; `div_in` becomes the active `div` at that wrap, and `div_pend` stays 0.
- `sync_clr` has priority over `enable` and over wraps. On a `sync_clr` edge, for all channels:
  - `count`←0 and `tick`←0.
  - Any pending divisor is applied and `div_pend`←0.
  - A `div_wr` in the same cycle is applied immediately.
- Counter arithmetic is CNT_W-bit unsigned. `count` never exceeds `div`−1, so there is no wrap-around beyond the divisor.
- Reset (asynchronous, any time including mid-period): `count`=0, `div`=DEFAULT_DIV, `pend_div`=DEFAULT_DIV, `div_pend`=0, `tick`=0.

## Timing
- `tick` is registered, with no combinational path from any input to `tick` or `div_pend`.
- First tick after reset release occurs `div` enabled edges later. It is visible after the DEFAULT_DIV-th edge with `enable`=1.
- Period is exactly `div` advanced cycles, with a duty of 1/`div`.
- The new divisor takes effect after the current period completes; no shortened or lengthened period is ever produced.
- `div_pend` rises the edge after `div_wr` and falls on the edge of the wrap that consumes the value.
- CASCADE=1: `tick[i]` is asserted in the same cycle as `tick[i−1]` on the edge where i−1 wraps. The period of channel i is the product of the divisors of channels 0..i.

## Structure
- Package `clk_enable_pkg`:
  - `DEFAULT_DIV_C`.
  - A `ch_state_t` struct holding `count`, `div`, `pend_div` and `pend`.
  - A helper function `ch_sel_w(NUM_CH)` returning the `div_ch` width.
- Sub-module `clk_div_channel`: one channel, with inputs `adv`, `clr`, `wr`, `wr_data` and outputs `tick`, `wrap`, `pend`.
- Top level: generate-loop of `clk_div_channel`, plus the write decode and cascade chaining of `adv` from the previous channel's `wrap`.

## Test plan
- Reset, `enable`=1, defaults (DEFAULT_DIV=4) → `tick[0]` high on edges 4, 8, 12, … and low otherwise; all outputs 0 during reset.
- Write `div_in`=6 to ch0 at mid-period (count=1) → current period still 4; `div_pend`=1 until the wrap; subsequent ticks every 6 cycles.
- Drop `enable` for 3 cycles at count=2 → `tick` stays 0 and the count freezes; the next tick is delayed by exactly 3 cycles.
- CASCADE=1, div0=4, div1=3 → `tick[1]` every 12 cycles, coincident with every third `tick[0]`.
- `sync_clr` with ch1 pending div=5, plus `div_wr` to ch0 (div=2) in the same cycle → both applied immediately, counts 0, first ticks 2 and 5 cycles later; `div_ch`=NUM_CH write ignored.
- Assert `reset` asynchronously mid-clock with count=3 and `tick` about to fire → `tick`=0 and `count`=0 immediately; `div` returns to 4.

Source files
------------

// File: rtl/clk_enable_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
//   DEFAULT_DIV_C : divisor loaded on reset (100 MHz -> 25 MHz pixel tick)
//   CNT_W_MAX     : widest counter/divisor a channel can be built with
//   ch_state_t    : per-channel state (count, active div, pending div, pend flag)
//   ch_sel_w()    : width of the channel-select field, never below 1
package clk_enable_pkg;

    localparam int unsigned DEFAULT_DIV_C = 4;
    localparam int unsigned CNT_W_MAX     = 16;

    // Fields are stored at full width; values never exceed 2^CNT_W-1.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] count;
        logic [CNT_W_MAX-1:0] div;
        logic [CNT_W_MAX-1:0] pend_div;
        logic                 pend;
    } ch_state_t;

    function automatic int unsigned ch_sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counts advance cycles and emits a registered tick
// every div advances; a new divisor is only adopted at the wrap point.
//   clk, reset : clock, asynchronous active-high reset
//   adv        : advance this cycle (enable or previous channel's wrap)
//   clr        : synchronous realign (count to 0, apply pending divisor)
//   wr/wr_data : divisor write for this channel
//   tick       : registered one-cycle enable pulse
//   wrap       : combinational, high in the cycle that produces the next tick
//   pend       : registered, a written divisor waits for the wrap
module clk_div_channel
    import clk_enable_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             tick,
    output logic             wrap,
    output logic             pend
);

    ch_state_t            st_q;
    ch_state_t            st_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 parked;
    logic [CNT_W_MAX-1:0] wr_val;

    assign wr_val = CNT_W_MAX'(wr_data);
    assign parked = (st_q.div == '0);
    assign wrap   = adv && !parked && (st_q.count == st_q.div - CNT_W_MAX'(1));

    // Next-state: realign > parked > wrap > plain count
    always_comb begin
        st_d   = st_q;
        tick_d = 1'b0;
        if (clr) begin
            st_d.count = '0;
            if (wr) begin
                st_d.div = wr_val;
            end else if (st_q.pend) begin
                st_d.div = st_q.pend_div;
            end
            st_d.pend_div = st_d.div;
            st_d.pend     = 1'b0;
        end else if (parked) begin
            // A parked channel never wraps, so a pending value is taken at once;
            // a write in this cycle queues behind it.
            st_d.count = '0;
            if (st_q.pend) begin
                st_d.div  = st_q.pend_div;
                st_d.pend = 1'b0;
            end
            if (wr) begin
                st_d.pend_div = wr_val;
                st_d.pend     = 1'b1;
            end
        end else if (wrap) begin
            st_d.count = '0;
            tick_d     = 1'b1;
            if (wr) begin
                // Write coinciding with the wrap bypasses the pending stage
                st_d.div      = wr_val;
                st_d.pend_div = wr_val;
                st_d.pend     = 1'b0;
            end else if (st_q.pend) begin
                st_d.div  = st_q.pend_div;
                st_d.pend = 1'b0;
            end
        end else begin
            if (adv) begin
                st_d.count = st_q.count + CNT_W_MAX'(1);
            end
            if (wr) begin
                st_d.pend_div = wr_val;
                st_d.pend     = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q.count    <= '0;
            st_q.div      <= CNT_W_MAX'(DEFAULT_DIV);
            st_q.pend_div <= CNT_W_MAX'(DEFAULT_DIV);
            st_q.pend     <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            st_q   <= st_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign pend = st_q.pend;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with glitch-free divisor updates and
// optional cascading (channel i counts wraps of channel i-1).
//   clk, reset : clock, asynchronous active-high reset
//   enable     : global count enable
//   sync_clr   : synchronous realign of all channels
//   div_wr     : divisor write strobe, div_ch selects channel, div_in is value
//   tick       : per-channel registered one-cycle enable pulse
//   div_pend   : per-channel flag, written divisor waiting for the wrap
module clk_enable_gen
    import clk_enable_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
    parameter int unsigned CASCADE     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sync_clr,
    input  logic                          div_wr,
    input  logic [ch_sel_w(NUM_CH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]              div_in,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             div_pend
);

    localparam int unsigned CH_W = ch_sel_w(NUM_CH);

    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] wr;
    logic              unused_wrap;

    // The last wrap (and all of them when not cascaded) feeds nothing
    assign unused_wrap = ^wrap;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel selects never match, so they are dropped
        assign wr[i] = div_wr && (div_ch == CH_W'(i));

        if (i == 0 || CASCADE == 0) begin : g_adv_en
            assign adv[i] = enable;
        end else begin : g_adv_cas
            assign adv[i] = wrap[i-1];
        end

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv[i]),
            .clr     (sync_clr),
            .wr      (wr[i]),
            .wr_data (div_in),
            .tick    (tick[i]),
            .wrap    (wrap[i]),
            .pend    (div_pend[i])
        );
    end

endmodule
